// File: rtl/game_judge.sv
// Keypad sequence judge: synchronises and debounces key_in, detects digit presses,
// tracks progress through TARGET and raises registered win / game-over flags.
module game_judge #(
   parameter int                   SEQ_LEN    = 4,
   parameter int                   MAX_MISS   = 3,
   parameter int                   DEB_CYCLES = 20000,
   parameter logic [SEQ_LEN*4-1:0] TARGET     = 16'h1357
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_in,
   input  logic       timeover,
   output logic       success,
   output logic       dot_game_over,
   output logic [1:0] miss_count,
   output logic [2:0] digit_pos,
   output logic       key_accept
);

   localparam int         CW        = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
   localparam logic [2:0] LAST_POS  = 3'(SEQ_LEN - 1);
   localparam logic [1:0] MISS_LAST = 2'(MAX_MISS - 1);
   localparam logic [3:0] NO_KEY    = 4'hF;

   typedef enum logic [1:0] {PLAY, WIN, LOSE, TIMEOUT} state_t;

   logic [3:0]    r_s1, r_s2, r_s2_prev;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_stable, r_stable_prev;
   logic          r_armed;
   state_t        r_state;
   logic [2:0]    r_pos;
   logic [1:0]    r_miss;
   logic          r_accept, r_success, r_over;

   logic [CW-1:0] w_cnt_nxt;
   logic          w_load;
   logic          w_event;
   logic [3:0]    w_target;
   state_t        w_state_nxt;
   logic [2:0]    w_pos_nxt;
   logic [1:0]    w_miss_nxt;
   logic          w_accept_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (r_s2 != r_s2_prev)
         w_cnt_nxt = '0;
      else if (r_cnt != CNT_MAX)
         w_cnt_nxt = r_cnt + 1'b1;
   end

   // stable_key loads on the edge the counter reaches its terminal value
   assign w_load = (w_cnt_nxt == CNT_MAX);

   // A key held across reset must be released once before it can count as a press
   assign w_event = r_armed && (r_stable_prev == NO_KEY) && (r_stable <= 4'd9);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1          <= NO_KEY;
         r_s2          <= NO_KEY;
         r_s2_prev     <= NO_KEY;
         r_cnt         <= '0;
         r_stable      <= NO_KEY;
         r_stable_prev <= NO_KEY;
         r_armed       <= 1'b0;
      end else begin
         r_s1          <= key_in;
         r_s2          <= r_s1;
         r_s2_prev     <= r_s2;
         r_cnt         <= w_cnt_nxt;
         r_stable_prev <= r_stable;
         if (w_load) begin
            r_stable <= r_s2;
            if (r_s2 == NO_KEY)
               r_armed <= 1'b1;
         end
      end
   end

   always_comb begin
      w_target = 4'h0;
      for (int i = 0; i < SEQ_LEN; i++)
         if (r_pos == 3'(i))
            w_target = TARGET[(SEQ_LEN-1-i)*4 +: 4];
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pos_nxt    = r_pos;
      w_miss_nxt   = r_miss;
      w_accept_nxt = 1'b0;
      case (r_state)
         PLAY: begin
            if (timeover) begin
               w_state_nxt = TIMEOUT;
            end else if (w_event) begin
               w_accept_nxt = 1'b1;
               if (r_stable == w_target) begin
                  if (r_pos == LAST_POS)
                     w_state_nxt = WIN;
                  else
                     w_pos_nxt = r_pos + 3'd1;
               end else begin
                  w_pos_nxt  = 3'd0;
                  w_miss_nxt = r_miss + 2'd1;
                  if (r_miss == MISS_LAST)
                     w_state_nxt = LOSE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= PLAY;
         r_pos     <= 3'd0;
         r_miss    <= 2'd0;
         r_accept  <= 1'b0;
         r_success <= 1'b0;
         r_over    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pos     <= w_pos_nxt;
         r_miss    <= w_miss_nxt;
         r_accept  <= w_accept_nxt;
         r_success <= (w_state_nxt == WIN);
         r_over    <= (w_state_nxt == LOSE);
      end
   end

   assign success       = r_success;
   assign dot_game_over = r_over;
   assign miss_count    = r_miss;
   assign digit_pos     = r_pos;
   assign key_accept    = r_accept;

endmodule

// File: tb/tb_game_judge.sv
// Directed bench for game_judge with a short debounce window.
module tb_game_judge;

   logic       clk;
   logic       reset;
   logic [3:0] key_in;
   logic       timeover;
   logic       success;
   logic       dot_game_over;
   logic [1:0] miss_count;
   logic [2:0] digit_pos;
   logic       key_accept;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int g_pulses;
   int g_at;
   int g_flags;

   game_judge #(
      .SEQ_LEN   (4),
      .MAX_MISS  (3),
      .DEB_CYCLES(4),
      .TARGET    (16'h1357)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_in       (key_in),
      .timeover     (timeover),
      .success      (success),
      .dot_game_over(dot_game_over),
      .miss_count   (miss_count),
      .digit_pos    (digit_pos),
      .key_accept   (key_accept)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold v for n edges; record accept pulses, first pulse edge, and any flag activity.
   task automatic drive(input logic [3:0] v, input int n);
      key_in   = v;
      g_pulses = 0;
      g_at     = -1;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (key_accept === 1'b1) begin
            g_pulses++;
            if (g_at < 0) g_at = i;
         end
         if (success !== 1'b0 || dot_game_over !== 1'b0) g_flags++;
      end
   endtask

   task automatic press(input string tag, input logic [3:0] d, input int exp_pulses);
      int pulses;
      int at;
      drive(d, 10);
      pulses = g_pulses;
      at     = g_at;
      drive(4'hF, 10);
      pulses += g_pulses;
      check({tag, "_pulses"}, pulses, exp_pulses);
      if (exp_pulses == 1) check({tag, "_latency"}, at, 7);
   endtask

   task automatic reset_mid_cycle(input string tag);
      #4;
      reset = 1'b1;
      #1;
      check(tag, {success, dot_game_over, miss_count, digit_pos, key_accept}, 0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      key_in = 4'hF;
      drive(4'hF, 10);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      key_in   = 4'hF;
      timeover = 1'b0;
      g_flags  = 0;

      // 1. Reset values; key held through reset release is not a press
      tick();
      check("reset_outputs", {success, dot_game_over, miss_count, digit_pos, key_accept}, 0);
      key_in = 4'h1;
      tick(); tick(); tick();
      reset = 1'b0;
      drive(4'h1, 20);
      check("held_through_reset", g_pulses, 0);
      drive(4'hF, 10);
      check("release_no_event", g_pulses, 0);
      press("rearm_press", 4'h1, 1);
      check("rearm_pos", digit_pos, 1);

      // 2. Correct sequence from a clean start
      reset_mid_cycle("reset_mid_play");
      press("seq1", 4'h1, 1);
      check("seq1_pos", digit_pos, 1);
      press("seq3", 4'h3, 1);
      check("seq3_pos", digit_pos, 2);
      press("seq5", 4'h5, 1);
      check("seq5_pos", digit_pos, 3);
      press("seq7", 4'h7, 1);
      check("seq7_pos", digit_pos, 3);
      check("seq_flags", {success, dot_game_over}, 2'b10);
      press("win_ignored", 4'h1, 0);
      check("win_hold", {success, dot_game_over, digit_pos}, {2'b10, 3'd3});

      // 6. Recovery from WIN
      reset_mid_cycle("reset_from_win");
      press("rec1", 4'h1, 1);
      press("rec3", 4'h3, 1);
      press("rec5", 4'h5, 1);
      press("rec7", 4'h7, 1);
      check("rec_success", {success, dot_game_over}, 2'b10);

      // 3. Misses
      reset_mid_cycle("reset_for_miss");
      press("miss_a", 4'h1, 1);
      press("miss_b", 4'h2, 1);
      check("miss1", {miss_count, digit_pos}, {2'd1, 3'd0});
      press("miss_c", 4'h9, 1);
      check("miss2", {miss_count, digit_pos}, {2'd2, 3'd0});
      press("miss_d", 4'h0, 1);
      check("miss3", {success, dot_game_over, miss_count, digit_pos}, {2'b01, 2'd3, 3'd0});
      press("lose_ignored", 4'h1, 0);
      check("lose_hold", {success, dot_game_over, miss_count}, {2'b01, 2'd3});

      // 4. Bounce and non-digit keys
      reset_mid_cycle("reset_for_bounce");
      g_pulses = 0;
      begin
         int bounce_pulses;
         bounce_pulses = 0;
         for (int k = 0; k < 5; k++) begin
            drive(4'h1, 2);
            bounce_pulses += g_pulses;
            drive(4'hF, 2);
            bounce_pulses += g_pulses;
         end
         drive(4'hF, 10);
         bounce_pulses += g_pulses;
         check("bounce_pulses", bounce_pulses, 0);
      end
      check("bounce_state", {success, dot_game_over, miss_count, digit_pos}, 0);
      press("code_b", 4'hB, 0);
      check("code_b_state", {miss_count, digit_pos}, 0);
      begin
         int ab_pulses;
         drive(4'h1, 10);
         ab_pulses = g_pulses;
         check("press_after_b", g_at, 7);
         drive(4'hB, 10);
         ab_pulses += g_pulses;
         drive(4'h1, 10);
         ab_pulses += g_pulses;
         drive(4'hF, 10);
         ab_pulses += g_pulses;
         check("b_not_release", ab_pulses, 1);
         check("b_not_release_pos", digit_pos, 1);
      end

      // 5. Timeout beats a same-edge accept
      reset_mid_cycle("reset_for_timeout");
      press("to1", 4'h1, 1);
      press("to3", 4'h3, 1);
      drive(4'h5, 6);
      check("to_pre_edge", g_pulses, 0);
      timeover = 1'b1;
      tick();
      timeover = 1'b0;
      check("to_suppressed", {key_accept, digit_pos}, {1'b0, 3'd2});
      drive(4'hF, 10);
      begin
         int to_pulses;
         to_pulses = g_pulses;
         g_flags   = 0;
         for (int k = 0; k < 5; k++) begin
            drive(4'h5, 10);
            to_pulses += g_pulses;
            drive(4'hF, 10);
            to_pulses += g_pulses;
         end
         check("to_no_pulses", to_pulses, 0);
         check("to_no_flags", g_flags, 0);
         check("to_pos_hold", {miss_count, digit_pos}, {2'd0, 3'd2});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
